// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// FSM state encoding, digit count, dark pattern and the hex-to-segment table.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   localparam int NUM_DIGITS = 8;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for 0..F.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic logic [NUM_DIGITS-1:0] an_onehot_n(
      input logic [NUM_DIGITS-1:0] mask,
      input logic [2:0]            idx
   );
      an_onehot_n = ~({{(NUM_DIGITS-1){1'b0}}, mask[idx]} << idx);
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the scan controller: enables, mux feedback and pin drives.
// The master modport is the controller, the slave modport is the board/mux side.
interface seg_scan_ctrl_if;
   import seg_pkg::*;

   logic                  en;
   logic [NUM_DIGITS-1:0] digit_mask;
   logic [NUM_DIGITS-1:0] dp_in;
   logic [3:0]            mux_data;
   logic [2:0]            sel;
   logic [6:0]            seg_n;
   logic                  dp_n;
   logic [NUM_DIGITS-1:0] an_n;
   logic                  frame_done;

   modport master (
      input  en, digit_mask, dp_in, mux_data,
      output sel, seg_n, dp_n, an_n, frame_done
   );

   modport slave (
      output en, digit_mask, dp_in, mux_data,
      input  sel, seg_n, dp_n, an_n, frame_done
   );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg_n
);

   assign o_seg_n = HEX_SEG[i_hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode scan controller.
// Optional inter-digit dark gap is built when SEG_SCAN_BLANK_EN is defined.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 12_500,
   parameter int BLANK_CYCLES = 250
) (
   input  logic               clk,
   input  logic               rst,
   seg_scan_ctrl_if.master    bus
);

   localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Elaboration-time guard on the slot geometry.
   if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_cfg_err
      $error("seg_scan_ctrl: BLANK_CYCLES must be in [1, DIGIT_CYCLES)");
   end

`ifdef SEG_SCAN_BLANK_EN
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [2:0]            r_sel;
   logic [6:0]            r_seg_n;
   logic                  r_dp_n;
   logic [NUM_DIGITS-1:0] r_an_n;
   logic                  r_frame_done;

   logic [6:0]            w_seg_n;
   logic [2:0]            w_sel_nxt;

   assign w_sel_nxt = r_sel + 3'd1;

   seg_hex_decode u_dec (
      .i_hex   (bus.mux_data),
      .o_seg_n (w_seg_n)
   );

   // Scan FSM: slot counter, digit select and all registered pin drives.
   always_ff @(posedge clk) begin
      if (rst || !bus.en) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_sel        <= 3'd0;
         r_seg_n      <= SEG_OFF;
         r_dp_n       <= 1'b1;
         r_an_n       <= '1;
         r_frame_done <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt        <= '0;
               r_sel        <= 3'd0;
               r_frame_done <= 1'b0;
`ifdef SEG_SCAN_BLANK_EN
               r_state      <= ST_BLANK;
               r_seg_n      <= SEG_OFF;
               r_dp_n       <= 1'b1;
               r_an_n       <= '1;
`else
               r_state      <= ST_DRIVE;
               r_seg_n      <= w_seg_n;
               r_dp_n       <= ~bus.dp_in[0];
               r_an_n       <= an_onehot_n(bus.digit_mask, 3'd0);
`endif
            end
`ifdef SEG_SCAN_BLANK_EN
            ST_BLANK: begin
               r_cnt        <= r_cnt + CNT_ONE;
               r_frame_done <= 1'b0;
               if (r_cnt == BLANK_LAST) begin
                  r_state <= ST_DRIVE;
                  r_seg_n <= w_seg_n;
                  r_dp_n  <= ~bus.dp_in[r_sel];
                  r_an_n  <= an_onehot_n(bus.digit_mask, r_sel);
               end else begin
                  r_state <= ST_BLANK;
                  r_seg_n <= SEG_OFF;
                  r_dp_n  <= 1'b1;
                  r_an_n  <= '1;
               end
            end
`endif
            ST_DRIVE: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt        <= '0;
                  r_sel        <= w_sel_nxt;
                  r_frame_done <= (r_sel == 3'd7);
`ifdef SEG_SCAN_BLANK_EN
                  r_state      <= ST_BLANK;
                  r_seg_n      <= SEG_OFF;
                  r_dp_n       <= 1'b1;
                  r_an_n       <= '1;
`else
                  // No gap: next anode turns on while mux_data still reflects the old sel.
                  r_state      <= ST_DRIVE;
                  r_seg_n      <= w_seg_n;
                  r_dp_n       <= ~bus.dp_in[w_sel_nxt];
                  r_an_n       <= an_onehot_n(bus.digit_mask, w_sel_nxt);
`endif
               end else begin
                  r_state      <= ST_DRIVE;
                  r_cnt        <= r_cnt + CNT_ONE;
                  r_frame_done <= 1'b0;
                  r_seg_n      <= w_seg_n;
                  r_dp_n       <= ~bus.dp_in[r_sel];
                  r_an_n       <= an_onehot_n(bus.digit_mask, r_sel);
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_cnt        <= '0;
               r_sel        <= 3'd0;
               r_seg_n      <= SEG_OFF;
               r_dp_n       <= 1'b1;
               r_an_n       <= '1;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sel        = r_sel;
   assign bus.seg_n      = r_seg_n;
   assign bus.dp_n       = r_dp_n;
   assign bus.an_n       = r_an_n;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (DIGIT_CYCLES=8, BLANK_CYCLES=2).
// Expectations follow SEG_SCAN_BLANK_EN the same way the design build does.
module tb_seg_scan_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg_scan_ctrl_if bus();

   logic       ovr_en;
   logic [3:0] ovr_val;

   // Mux model: returns the selected digit index unless overridden.
   assign bus.mux_data = ovr_en ? ovr_val : {1'b0, bus.sel};

   seg_scan_ctrl #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef SEG_SCAN_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'h0: seg_of = 7'b1000000;
         4'h1: seg_of = 7'b1111001;
         4'h2: seg_of = 7'b0100100;
         4'h3: seg_of = 7'b0110000;
         4'h4: seg_of = 7'b0011001;
         4'h5: seg_of = 7'b0010010;
         4'h6: seg_of = 7'b0000010;
         4'h7: seg_of = 7'b1111000;
         4'h8: seg_of = 7'b0000000;
         4'h9: seg_of = 7'b0010000;
         4'hA: seg_of = 7'b0001000;
         4'hB: seg_of = 7'b0000011;
         4'hC: seg_of = 7'b1000110;
         4'hD: seg_of = 7'b0100001;
         4'hE: seg_of = 7'b0000110;
         default: seg_of = 7'b0001110;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Enables the scan from IDLE and checks n cycles; k=0 is the cycle after the enabling edge.
   task automatic run_scan(input int n);
      int digit, pos;
      bit lit;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      bus.en = 1'b1;
      for (int k = 0; k < n; k++) begin
         tick;
         digit = (k / 8) % 8;
         pos   = k % 8;
         lit   = BLANK_ON ? (pos >= 2) : 1'b1;
         exp_an = (lit && bus.digit_mask[digit]) ? ~(8'd1 << digit) : 8'hFF;
         if (!lit)
            exp_seg = 7'h7F;
         else if (ovr_en)
            exp_seg = seg_of(ovr_val);
         else if (!BLANK_ON && pos == 0 && k > 0)
            exp_seg = seg_of(4'((digit + 7) % 8));
         else
            exp_seg = seg_of(4'(digit));
         exp_dp = lit ? ~bus.dp_in[digit] : 1'b1;
         check_eq($sformatf("an_n k=%0d", k), 32'(bus.an_n), 32'(exp_an));
         check_eq($sformatf("sel k=%0d", k), 32'(bus.sel), 32'(digit));
         check_eq($sformatf("seg_n k=%0d", k), 32'(bus.seg_n), 32'(exp_seg));
         check_eq($sformatf("dp_n k=%0d", k), 32'(bus.dp_n), 32'(exp_dp));
         check_eq($sformatf("frame_done k=%0d", k), 32'(bus.frame_done),
                  32'((k > 0) && (k % 64 == 0)));
      end
   endtask

   // Aborts during the 3rd lit cycle of digit 5 by en drop or rst, then re-enables.
   task automatic abort_check(input bit use_rst);
      bus.en = 1'b0;
      tick;
      run_scan(BLANK_ON ? 45 : 43);
      if (use_rst) rst = 1'b1;
      else         bus.en = 1'b0;
      tick;
      check_eq("abort an_n", 32'(bus.an_n), 32'h0000_00FF);
      check_eq("abort sel", 32'(bus.sel), 32'd0);
      check_eq("abort seg_n", 32'(bus.seg_n), 32'h0000_007F);
      check_eq("abort dp_n", 32'(bus.dp_n), 32'd1);
      check_eq("abort frame_done", 32'(bus.frame_done), 32'd0);
      rst    = 1'b0;
      bus.en = 1'b1;
      tick;
      check_eq("restart sel", 32'(bus.sel), 32'd0);
      check_eq("restart an_n", 32'(bus.an_n), BLANK_ON ? 32'h0000_00FF : 32'h0000_00FE);
   endtask

   initial begin
      rst            = 1'b1;
      bus.en         = 1'b0;
      bus.digit_mask = 8'hFF;
      bus.dp_in      = 8'h00;
      ovr_en         = 1'b0;
      ovr_val        = 4'h0;
      repeat (3) tick;
      check_eq("rst an_n", 32'(bus.an_n), 32'h0000_00FF);
      check_eq("rst seg_n", 32'(bus.seg_n), 32'h0000_007F);
      check_eq("rst dp_n", 32'(bus.dp_n), 32'd1);
      check_eq("rst sel", 32'(bus.sel), 32'd0);
      check_eq("rst frame_done", 32'(bus.frame_done), 32'd0);
      rst = 1'b0;
      tick;

      // Full scan, all digits enabled, decimal point on digit 3.
      bus.dp_in = 8'h08;
      run_scan(136);
      bus.en = 1'b0;
      tick;

      // Override data 4'hA.
      bus.dp_in = 8'h00;
      ovr_en    = 1'b1;
      ovr_val   = 4'hA;
      run_scan(16);
      ovr_en = 1'b0;
      bus.en = 1'b0;
      tick;

      // Masked digits keep their slots.
      bus.digit_mask = 8'b0000_0101;
      bus.dp_in      = 8'h08;
      run_scan(130);
      bus.en = 1'b0;
      tick;
      bus.digit_mask = 8'hFF;
      bus.dp_in      = 8'h00;

      abort_check(1'b0);
      abort_check(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 8-digit common-anode seven-segment display. It drives the 3-bit select of the 8:1 nibble display mux and receives the selected 4-bit value back. It decodes that value to active-low segments and strobes one active-low anode at a time, with a programmable dark gap between digits to suppress ghosting. It sits between the UART TX status/data registers (which feed the mux inputs) and the board display pins.

## Interface
- `DIGIT_CYCLES`, 12_500: clock cycles per digit slot; frame = 8 × DIGIT_CYCLES (1 ms at 100 MHz).
- `BLANK_CYCLES`, 250: dark cycles at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous, active-high reset.
- `en  in  1`: scan enable; 0 forces display dark.
- `digit_mask  in  8`: per-digit enable; a masked digit stays dark but keeps its slot.
- `dp_in  in  8`: decimal point request per digit, active-high.
- `mux_data  in  4`: nibble returned by the display mux for the current `sel`.
- `sel  out  3`: display mux select, equal to the current digit index.
- `seg_n  out  7`: segments {g,f,e,d,c,b,a}, active-low.
- `dp_n  out  1`: decimal point, active-low.
- `an_n  out  8`: anodes, active-low, at most one low.
- `frame_done  out  1`: one-cycle pulse when digit 7's slot ends.

## Operation
- States:
  - IDLE: outputs dark.
  - BLANK: `sel` valid, anodes off.
  - DRIVE: one anode on.
- All outputs are registered. Reset values: state IDLE, `sel`=0, `an_n`=8'hFF, `seg_n`=7'h7F, `dp_n`=1, `frame_done`=0, slot counter 0.
- IDLE: when `en`=1 → BLANK with `sel`=0 and counter 0.
- BLANK: counter counts 0..BLANK_CYCLES-1. On the last count → DRIVE.
- DRIVE:
  - Every cycle: `seg_n` ← decode(`mux_data`) and `dp_n` ← ~`dp_in[sel]`, so live data changes show with 1-cycle latency.
  - `an_n` ← ~(`digit_mask[sel]` << `sel`).
  - Counter continues to DIGIT_CYCLES-1.
  - At the end of the slot: `sel` ← `sel`+1 (wrapping 7→0), counter ← 0, state → BLANK, `an_n`/`seg_n`/`dp_n` go dark.
  - `frame_done` pulses on the 7→0 wrap.
- Decode covers hex 0–F, all 16 codes defined. No segment lit on an undefined input is impossible by construction.
- `en`=0 in any state: on the next edge → IDLE, outputs dark, `sel`=0, counter 0. Re-enabling restarts at digit 0 BLANK.
- `rst` has priority over `en` and has the same effect as reset.
- `digit_mask`/`dp_in` changes take effect on the next DRIVE-cycle register update. No slot-time change.

## Timing
- `sel` changes on the edge entering BLANK. Mux data is therefore stable for BLANK_CYCLES before the anode turns on.
- The anode turns on at the edge entering DRIVE, using `mux_data` sampled at that edge.
- Per slot: BLANK_CYCLES dark, then DIGIT_CYCLES−BLANK_CYCLES lit. The frame is exactly 8×DIGIT_CYCLES cycles, independent of `digit_mask`.
- `frame_done` is high for exactly 1 cycle, coincident with the first BLANK cycle of digit 0.
- Counter width is $clog2(DIGIT_CYCLES). No counter wraps other than the slot end.

## Configuration
- `SEG_SCAN_BLANK_EN` defined: BLANK state present, behaviour as above.
- Undefined: BLANK state and `BLANK_CYCLES` are ignored.
  - IDLE goes directly to DRIVE.
  - Each slot is DIGIT_CYCLES lit cycles.
  - The anode switches from digit n to n+1 on the same edge `sel` changes, with `seg_n` one cycle stale at the switch.

## Structure
- Package `seg_pkg`:
  - state enum (IDLE/BLANK/DRIVE)
  - `NUM_DIGITS`=8
  - `SEG_OFF`=7'h7F
  - the 16-entry hex→segment pattern constant
- Sub-module `seg_hex_decode`: 4-bit in, 7-bit active-low out, purely combinational. It is instantiated once, on `mux_data`.

## Test plan
Bench parameters DIGIT_CYCLES=8, BLANK_CYCLES=2; mux model returns `sel` value as data.
- Reset: `rst` high 3 cycles → `an_n`=8'hFF, `seg_n`=7'h7F, `dp_n`=1, `sel`=0, `frame_done`=0.
- Full scan:
  - Stimulus: `en`=1, `digit_mask`=8'hFF.
  - Each digit i: dark 2 cycles, then `an_n`=~(1<<i) for 6 cycles.
  - Digit 1 → `seg_n`=7'b1111001; digit 8'hA at index... via override data 4'hA → 7'b0001000.
  - `frame_done` pulses every 64 cycles.
- Mask: `digit_mask`=8'b0000_0101 → only `an_n[0]`, `an_n[2]` ever low; frame still 64 cycles.
- Decimal point: `dp_in`=8'h08 → `dp_n`=0 only during digit 3's 6 lit cycles.
- Abort: drop `en` during the 3rd lit cycle of digit 5 → next edge `an_n`=8'hFF, `sel`=0. Re-enable → digit 0 BLANK. The same check applies with `rst` asserted instead of dropping `en`.
- Macro undefined: `an_n` steps ~(1<<i) every 8 cycles with no all-high gap; `frame_done` still every 64 cycles.
